// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if
//   Bundles the requester handshake, the response channel and the SPI register
//   bus used by spi_txn_arbiter.
//   slave  : arbiter view. It receives requests and drives the register bus.
//   master : environment view. Requesters and the SPI register block use it.
//   Signals:
//     req_valid/req_cmd/req_addr/req_wdata  flattened per-requester requests
//     req_ready                             one-hot accept pulse
//     rsp_valid/rsp_id/rsp_data             transaction completion
//     busy                                  arbiter not idle
//     spi_addr/spi_we/spi_write_data/spi_re register bus to the SPI block
//     spi_read_data                         register read data from the SPI block
interface spi_txn_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*8-1:0]  req_cmd;
    logic [NUM_REQ*24-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [31:0]           rsp_data;
    logic                  busy;
    logic [2:0]            spi_addr;
    logic                  spi_we;
    logic [31:0]           spi_write_data;
    logic                  spi_re;
    logic [31:0]           spi_read_data;

    modport slave (
        input  req_valid, req_cmd, req_addr, req_wdata, spi_read_data,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy,
               spi_addr, spi_we, spi_write_data, spi_re
    );

    modport master (
        output req_valid, req_cmd, req_addr, req_wdata, spi_read_data,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy,
               spi_addr, spi_we, spi_write_data, spi_re
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//   Shares a single SPI register-interface wrapper among NUM_REQ requesters.
//   Requesters are granted one transaction at a time in round-robin order.
//   Each transaction is sequenced on the wrapper's register map:
//     CMD write, ADDR write, DIN write, EN=1, fixed transfer wait,
//     DOUT read (two cycles), EN=0.
//   The DOUT value is returned together with the requester id.
//   Ports:
//     clk  system clock. All logic runs on the rising edge.
//     rst  synchronous active-high reset. It aborts any transaction that is in flight.
//     bus  spi_txn_arbiter_if.slave, which carries the request, response and SPI register signals.
//   Parameters:
//     NUM_REQ      number of requesters (>=2)
//     XFER_CYCLES  cycles spent in WAIT after EN=1 (>=1)
module spi_txn_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int XFER_CYCLES = 96
) (
    input  logic               clk,
    input  logic               rst,
    spi_txn_arbiter_if.slave   bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(XFER_CYCLES + 1);

    // SPI block register map
    localparam logic [2:0] REG_EN   = 3'd0;
    localparam logic [2:0] REG_CMD  = 3'd1;
    localparam logic [2:0] REG_ADDR = 3'd2;
    localparam logic [2:0] REG_DIN  = 3'd3;
    localparam logic [2:0] REG_DOUT = 3'd4;

    typedef enum logic [3:0] {
        IDLE,
        W_CMD,
        W_ADDR,
        W_DATA,
        W_EN,
        WAIT,
        RD,
        CAP,
        W_DIS
    } state_t;

    state_t                      state;
    logic [IDW-1:0]              last;
    logic [IDW-1:0]              id_q;
    logic [7:0]                  cmd_q;
    logic [23:0]                 addr_q;
    logic [31:0]                 wdata_q;
    logic [CW-1:0]               cnt;
    logic [31:0]                 rsp_data_q;

    logic                        gnt_any;
    logic [IDW-1:0]              gnt_idx;
    logic [IDW-1:0]              j_idx;
    int                          j;
    logic [NUM_REQ-1:0]          rdy;

    // Unpacked per-requester views of the flattened payload buses
    logic [NUM_REQ-1:0][7:0]     cmd_v;
    logic [NUM_REQ-1:0][23:0]    addr_v;
    logic [NUM_REQ-1:0][31:0]    wdata_v;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign cmd_v[g]   = bus.req_cmd[g*8 +: 8];
        assign addr_v[g]  = bus.req_addr[g*24 +: 24];
        assign wdata_v[g] = bus.req_wdata[g*32 +: 32];
    end

    // Rotating-priority scan. The scan starts just after the last winner, so the
    // requester served most recently has the lowest priority next time.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        j       = 0;
        j_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j     = (int'(last) + k) % NUM_REQ;
            j_idx = IDW'(j);
            if (!gnt_any && bus.req_valid[j_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = j_idx;
            end
        end
    end

    // The accept pulse must share its cycle with the IDLE grant, so it is
    // combinational. It is gated by rst so that no request is acknowledged
    // while reset is blocking the capture.
    always_comb begin
        rdy = '0;
        if (state == IDLE && !rst && gnt_any)
            rdy[gnt_idx] = 1'b1;
    end
    assign bus.req_ready = rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= IDW'(NUM_REQ - 1);
            id_q       <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        cmd_q   <= cmd_v[gnt_idx];
                        addr_q  <= addr_v[gnt_idx];
                        wdata_q <= wdata_v[gnt_idx];
                        id_q    <= gnt_idx;
                        last    <= gnt_idx;
                        state   <= W_CMD;
                    end
                end
                W_CMD:  state <= W_ADDR;
                W_ADDR: state <= W_DATA;
                W_DATA: state <= W_EN;
                W_EN: begin
                    // WAIT lasts exactly XFER_CYCLES cycles, including the cycle where cnt==0
                    cnt   <= CW'(XFER_CYCLES - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) state <= RD;
                    else           cnt   <= cnt - 1'b1;
                end
                RD:  state <= CAP;
                CAP: begin
                    // The read strobe has already been held for a full cycle, so the DOUT value is stable here
                    rsp_data_q <= bus.spi_read_data;
                    state      <= W_DIS;
                end
                W_DIS:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode of the SPI-side strobes from the state register
    always_comb begin
        bus.spi_addr       = REG_EN;
        bus.spi_we         = 1'b0;
        bus.spi_re         = 1'b0;
        bus.spi_write_data = '0;
        bus.rsp_valid      = 1'b0;
        case (state)
            W_CMD: begin
                bus.spi_addr       = REG_CMD;
                bus.spi_we         = 1'b1;
                bus.spi_write_data = {24'b0, cmd_q};
            end
            W_ADDR: begin
                bus.spi_addr       = REG_ADDR;
                bus.spi_we         = 1'b1;
                bus.spi_write_data = {8'b0, addr_q};
            end
            W_DATA: begin
                bus.spi_addr       = REG_DIN;
                bus.spi_we         = 1'b1;
                bus.spi_write_data = wdata_q;
            end
            W_EN: begin
                bus.spi_addr       = REG_EN;
                bus.spi_we         = 1'b1;
                bus.spi_write_data = 32'd1;
            end
            RD, CAP: begin
                bus.spi_addr = REG_DOUT;
                bus.spi_re   = 1'b1;
            end
            W_DIS: begin
                bus.spi_addr       = REG_EN;
                bus.spi_we         = 1'b1;
                bus.spi_write_data = 32'd0;
                bus.rsp_valid      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.rsp_id   = id_q;
    assign bus.rsp_data = rsp_data_q;
endmodule
